alu_rs: RTL and testbench



---
 rtl/alu_rs.sv | 240 ++++++++++++++++++++++++
 tb/tb_alu_rs.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rs.sv
// ALU reservation station: multi-channel insert, forwarding capture, oldest-first issue.
// Define ALU_RS_FWD_BYPASS_EN to also capture forwards during the insert cycle.
module alu_rs #(
    parameter int DEPTH   = 16,
    parameter int NUM_IN  = 4,
    parameter int NUM_FWD = 4,
    parameter int DATA_W  = 16,
    parameter int TAG_W   = 6,
    parameter int OP_W    = 5
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_FWD*(1+TAG_W+DATA_W)-1:0] fwd,
    input  logic [NUM_IN-1:0]                   in_valid,
    input  logic [NUM_IN*OP_W-1:0]              in_op,
    input  logic [NUM_IN*TAG_W-1:0]             in_rob,
    input  logic [NUM_IN*TAG_W-1:0]             in_tag_a,
    input  logic [NUM_IN*TAG_W-1:0]             in_tag_b,
    input  logic [NUM_IN*DATA_W-1:0]            in_val_a,
    input  logic [NUM_IN*DATA_W-1:0]            in_val_b,
    input  logic [NUM_IN-1:0]                   in_rdy_a,
    input  logic [NUM_IN-1:0]                   in_rdy_b,
    output logic                                in_ready,
    output logic                                out_valid,
    output logic [OP_W-1:0]                     out_op,
    output logic [TAG_W-1:0]                    out_rob,
    output logic [DATA_W-1:0]                   out_a,
    output logic [DATA_W-1:0]                   out_b,
    input  logic                                out_ready,
    input  logic                                flush
);

    localparam int IW = $clog2(DEPTH);
    localparam int CW = IW + 1;
    localparam int FW = 1 + TAG_W + DATA_W;

    logic [DEPTH-1:0]  e_valid, e_rdy_a, e_rdy_b;
    logic [OP_W-1:0]   e_op    [DEPTH];
    logic [TAG_W-1:0]  e_rob   [DEPTH];
    logic [TAG_W-1:0]  e_tag_a [DEPTH];
    logic [TAG_W-1:0]  e_tag_b [DEPTH];
    logic [DATA_W-1:0] e_val_a [DEPTH];
    logic [DATA_W-1:0] e_val_b [DEPTH];
    logic [IW-1:0]     e_seq   [DEPTH];
    logic [IW-1:0]     head, head_nxt;

    logic [NUM_FWD-1:0] f_v;
    logic [TAG_W-1:0]   f_tag [NUM_FWD];
    logic [DATA_W-1:0]  f_val [NUM_FWD];

    always_comb begin
        for (int k = 0; k < NUM_FWD; k++) begin
            f_v[k]   = fwd[k*FW + FW - 1];
            f_tag[k] = fwd[k*FW + DATA_W +: TAG_W];
            f_val[k] = fwd[k*FW +: DATA_W];
        end
    end

    // Scan buses high to low so the lowest matching bus wins.
    logic [DEPTH-1:0]  hit_a, hit_b;
    logic [DATA_W-1:0] cap_a [DEPTH];
    logic [DATA_W-1:0] cap_b [DEPTH];

    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            hit_a[j] = 1'b0;
            hit_b[j] = 1'b0;
            cap_a[j] = '0;
            cap_b[j] = '0;
            for (int k = NUM_FWD - 1; k >= 0; k--) begin
                if (f_v[k] && f_tag[k] == e_tag_a[j]) begin
                    hit_a[j] = 1'b1;
                    cap_a[j] = f_val[k];
                end
                if (f_v[k] && f_tag[k] == e_tag_b[j]) begin
                    hit_b[j] = 1'b1;
                    cap_b[j] = f_val[k];
                end
            end
        end
    end

    logic [CW-1:0] free_cnt;

    always_comb begin
        free_cnt = '0;
        for (int j = 0; j < DEPTH; j++)
            free_cnt = free_cnt + {{IW{1'b0}}, ~e_valid[j]};
    end

    assign in_ready = free_cnt >= CW'(NUM_IN);

    // Ages are kept dense (0..live-1) relative to head so the ring never aliases.
    logic [IW-1:0] age [DEPTH];
    logic          sel_found, load, fire;
    logic [IW-1:0] sel_idx, sel_age;

    always_comb begin
        for (int j = 0; j < DEPTH; j++)
            age[j] = e_seq[j] - head;
    end

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_age   = '0;
        for (int j = 0; j < DEPTH; j++) begin
            if (e_valid[j] && e_rdy_a[j] && e_rdy_b[j] &&
                (!sel_found || age[j] < sel_age)) begin
                sel_found = 1'b1;
                sel_idx   = IW'(j);
                sel_age   = age[j];
            end
        end
    end

    assign load     = !out_valid || out_ready;
    assign fire     = load && sel_found;
    assign head_nxt = head + {{(IW-1){1'b0}}, fire};

    logic [NUM_IN-1:0] ins_en;
    logic [IW-1:0]     ins_idx [NUM_IN];
    logic [IW-1:0]     ins_seq [NUM_IN];
    logic [DEPTH-1:0]  avail;
    logic [IW-1:0]     live, ins_cnt;

    always_comb begin
        avail   = ~e_valid;
        live    = IW'(DEPTH - int'(free_cnt) - int'(fire));
        ins_cnt = '0;
        for (int c = 0; c < NUM_IN; c++) begin
            ins_en[c]  = 1'b0;
            ins_idx[c] = '0;
            ins_seq[c] = '0;
            if (in_ready && in_valid[c]) begin
                for (int j = 0; j < DEPTH; j++) begin
                    if (!ins_en[c] && avail[j]) begin
                        ins_en[c]  = 1'b1;
                        ins_idx[c] = IW'(j);
                        avail[j]   = 1'b0;
                    end
                end
                ins_seq[c] = head_nxt + live + ins_cnt;
                ins_cnt    = ins_cnt + IW'(1);
            end
        end
    end

    logic [NUM_IN-1:0] byp_a, byp_b;
    logic [DATA_W-1:0] byp_val_a [NUM_IN];
    logic [DATA_W-1:0] byp_val_b [NUM_IN];

`ifdef ALU_RS_FWD_BYPASS_EN
    always_comb begin
        for (int c = 0; c < NUM_IN; c++) begin
            byp_a[c]     = 1'b0;
            byp_b[c]     = 1'b0;
            byp_val_a[c] = '0;
            byp_val_b[c] = '0;
            for (int k = NUM_FWD - 1; k >= 0; k--) begin
                if (f_v[k] && f_tag[k] == in_tag_a[c*TAG_W +: TAG_W]) begin
                    byp_a[c]     = 1'b1;
                    byp_val_a[c] = f_val[k];
                end
                if (f_v[k] && f_tag[k] == in_tag_b[c*TAG_W +: TAG_W]) begin
                    byp_b[c]     = 1'b1;
                    byp_val_b[c] = f_val[k];
                end
            end
        end
    end
`else
    always_comb begin
        byp_a = '0;
        byp_b = '0;
        for (int c = 0; c < NUM_IN; c++) begin
            byp_val_a[c] = '0;
            byp_val_b[c] = '0;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            e_valid   <= '0;
            head      <= '0;
            out_valid <= 1'b0;
            out_op    <= '0;
            out_rob   <= '0;
            out_a     <= '0;
            out_b     <= '0;
        end else if (flush) begin
            e_valid   <= '0;
            head      <= '0;
            out_valid <= 1'b0;
        end else begin
            if (load) begin
                out_valid <= sel_found;
                if (sel_found) begin
                    out_op  <= e_op[sel_idx];
                    out_rob <= e_rob[sel_idx];
                    out_a   <= e_val_a[sel_idx];
                    out_b   <= e_val_b[sel_idx];
                end
            end
            head <= head_nxt;
            for (int j = 0; j < DEPTH; j++) begin
                if (fire && age[j] < sel_age)
                    e_seq[j] <= e_seq[j] + IW'(1);
                if (!e_rdy_a[j] && hit_a[j]) begin
                    e_rdy_a[j] <= 1'b1;
                    e_val_a[j] <= cap_a[j];
                end
                if (!e_rdy_b[j] && hit_b[j]) begin
                    e_rdy_b[j] <= 1'b1;
                    e_val_b[j] <= cap_b[j];
                end
            end
            if (fire)
                e_valid[sel_idx] <= 1'b0;
            for (int c = 0; c < NUM_IN; c++) begin
                if (ins_en[c]) begin
                    e_valid[ins_idx[c]] <= 1'b1;
                    e_op[ins_idx[c]]    <= in_op[c*OP_W +: OP_W];
                    e_rob[ins_idx[c]]   <= in_rob[c*TAG_W +: TAG_W];
                    e_tag_a[ins_idx[c]] <= in_tag_a[c*TAG_W +: TAG_W];
                    e_tag_b[ins_idx[c]] <= in_tag_b[c*TAG_W +: TAG_W];
                    e_seq[ins_idx[c]]   <= ins_seq[c];
                    e_rdy_a[ins_idx[c]] <= in_rdy_a[c] | byp_a[c];
                    e_rdy_b[ins_idx[c]] <= in_rdy_b[c] | byp_b[c];
                    e_val_a[ins_idx[c]] <= (!in_rdy_a[c] && byp_a[c]) ?
                        byp_val_a[c] : in_val_a[c*DATA_W +: DATA_W];
                    e_val_b[ins_idx[c]] <= (!in_rdy_b[c] && byp_b[c]) ?
                        byp_val_b[c] : in_val_b[c*DATA_W +: DATA_W];
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_rs.sv
// Scoreboard bench for alu_rs: issue order, forwarding, backpressure, full, flush, reset.
module tb_alu_rs;

    localparam int DEPTH   = 16;
    localparam int NUM_IN  = 4;
    localparam int NUM_FWD = 4;
    localparam int DATA_W  = 16;
    localparam int TAG_W   = 6;
    localparam int OP_W    = 5;
    localparam int FW      = 1 + TAG_W + DATA_W;

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [NUM_FWD*FW-1:0]    fwd = '0;
    logic [NUM_IN-1:0]        in_valid = '0;
    logic [NUM_IN*OP_W-1:0]   in_op = '0;
    logic [NUM_IN*TAG_W-1:0]  in_rob = '0;
    logic [NUM_IN*TAG_W-1:0]  in_tag_a = '0;
    logic [NUM_IN*TAG_W-1:0]  in_tag_b = '0;
    logic [NUM_IN*DATA_W-1:0] in_val_a = '0;
    logic [NUM_IN*DATA_W-1:0] in_val_b = '0;
    logic [NUM_IN-1:0]        in_rdy_a = '0;
    logic [NUM_IN-1:0]        in_rdy_b = '0;
    logic                     in_ready;
    logic                     out_valid;
    logic [OP_W-1:0]          out_op;
    logic [TAG_W-1:0]         out_rob;
    logic [DATA_W-1:0]        out_a;
    logic [DATA_W-1:0]        out_b;
    logic                     out_ready = 1'b0;
    logic                     flush = 1'b0;

    always #5 clk = ~clk;

    alu_rs #(
        .DEPTH(DEPTH), .NUM_IN(NUM_IN), .NUM_FWD(NUM_FWD),
        .DATA_W(DATA_W), .TAG_W(TAG_W), .OP_W(OP_W)
    ) dut (
        .clk(clk), .rst(rst), .fwd(fwd),
        .in_valid(in_valid), .in_op(in_op), .in_rob(in_rob),
        .in_tag_a(in_tag_a), .in_tag_b(in_tag_b),
        .in_val_a(in_val_a), .in_val_b(in_val_b),
        .in_rdy_a(in_rdy_a), .in_rdy_b(in_rdy_b),
        .in_ready(in_ready), .out_valid(out_valid), .out_op(out_op),
        .out_rob(out_rob), .out_a(out_a), .out_b(out_b),
        .out_ready(out_ready), .flush(flush)
    );

    int checks = 0;
    int errors = 0;
    logic [63:0] sb[$];

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack(input int op, input int rob,
                                         input int a, input int b);
        return {21'b0, OP_W'(op), TAG_W'(rob), DATA_W'(a), DATA_W'(b)};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic put(input int c, input int op, input int rob,
                       input int ta, input int tb, input int va,
                       input int vb, input bit ra, input bit rb);
        in_valid[c]                  = 1'b1;
        in_op[c*OP_W +: OP_W]        = OP_W'(op);
        in_rob[c*TAG_W +: TAG_W]     = TAG_W'(rob);
        in_tag_a[c*TAG_W +: TAG_W]   = TAG_W'(ta);
        in_tag_b[c*TAG_W +: TAG_W]   = TAG_W'(tb);
        in_val_a[c*DATA_W +: DATA_W] = DATA_W'(va);
        in_val_b[c*DATA_W +: DATA_W] = DATA_W'(vb);
        in_rdy_a[c]                  = ra;
        in_rdy_b[c]                  = rb;
    endtask

    task automatic bus(input int k, input int tag, input int val);
        fwd[k*FW +: FW] = {1'b1, TAG_W'(tag), DATA_W'(val)};
    endtask

    task automatic idle;
        in_valid = '0;
        fwd      = '0;
    endtask

    // Every handshake pops the oldest expected result.
    always @(negedge clk) begin
        if (!rst && !flush && out_valid && out_ready) begin
            if (sb.size() == 0)
                check("sb_extra", 64'(sb.size()), 64'd1);
            else
                check("out", pack(out_op, out_rob, out_a, out_b), sb.pop_front());
        end
    end

    initial begin
        tick;
        tick;
        rst = 1'b0;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_rob", 64'(out_rob), 64'd0);
        check("rst_out_a", 64'(out_a), 64'd0);

        // Two groups of ready ops; second inserted while the first issues.
        out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            put(c, c + 1, c + 1, 0, 0, 16 * (c + 1), 100 + c + 1, 1, 1);
            sb.push_back(pack(c + 1, c + 1, 16 * (c + 1), 100 + c + 1));
        end
        tick;
        check("t1_lat", 64'(out_valid), 64'd0);
        for (int c = 0; c < 4; c++) begin
            put(c, c + 5, c + 5, 0, 0, 16 * (c + 5), 100 + c + 5, 1, 1);
            sb.push_back(pack(c + 5, c + 5, 16 * (c + 5), 100 + c + 5));
        end
        tick;
        idle;
        check("t1_first_v", 64'(out_valid), 64'd1);
        check("t1_rob", 64'(out_rob), 64'd1);
        for (int i = 2; i <= 8; i++) begin
            tick;
            check("t1_rob", 64'(out_rob), 64'(i));
        end
        tick;
        check("t1_drain", 64'(out_valid), 64'd0);

        // Wait on tag 5; duplicate tag on bus 3 must lose to bus 2.
        put(0, 3, 9, 5, 0, 0, 7, 0, 1);
        tick;
        idle;
        tick;
        check("t2_wait", 64'(out_valid), 64'd0);
        bus(2, 5, 16'h1234);
        bus(3, 5, 16'h9999);
        sb.push_back(pack(3, 9, 16'h1234, 7));
        tick;
        idle;
        check("t2_cap", 64'(out_valid), 64'd0);
        tick;
        check("t2_issue", 64'(out_valid), 64'd1);
        check("t2_a", 64'(out_a), 64'h1234);
        tick;

        // Fill with waiting ops; inserts while full must be dropped.
        for (int g = 0; g < 4; g++) begin
            for (int c = 0; c < 4; c++)
                put(c, 1, 32 + g * 4 + c, 10 + g * 4 + c, 0, 0, g * 4 + c, 0, 1);
            tick;
        end
        idle;
        check("t3_full", 64'(in_ready), 64'd0);
        for (int c = 0; c < 4; c++)
            put(c, 2, 60 + c, 0, 0, 1, 1, 1, 1);
        tick;
        idle;
        check("t3_ign", 64'(in_ready), 64'd0);
        bus(0, 15, 16'h0500);
        sb.push_back(pack(1, 37, 16'h0500, 5));
        tick;
        idle;
        check("t3_cap", 64'(in_ready), 64'd0);
        tick;
        check("t3_one", 64'(out_rob), 64'd37);
        check("t3_free1", 64'(in_ready), 64'd0);
        for (int k = 0; k < 3; k++) begin
            bus(k, 10 + k, 16'h0100 + k);
            sb.push_back(pack(1, 32 + k, 16'h0100 + k, k));
        end
        tick;
        idle;
        tick;
        tick;
        check("t3_free3", 64'(in_ready), 64'd0);
        tick;
        check("t3_free4", 64'(in_ready), 64'd1);
        tick;

        // Hold outputs under backpressure.
        out_ready = 1'b0;
        bus(0, 13, 16'h0203);
        bus(1, 14, 16'h0204);
        bus(2, 16, 16'h0206);
        sb.push_back(pack(1, 35, 16'h0203, 3));
        sb.push_back(pack(1, 36, 16'h0204, 4));
        sb.push_back(pack(1, 38, 16'h0206, 6));
        tick;
        idle;
        tick;
        check("t4_v", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            tick;
            check("t4_hold", pack(out_op, out_rob, out_a, out_b),
                  pack(1, 35, 16'h0203, 3));
        end
        out_ready = 1'b1;
        tick;
        check("t4_next", 64'(out_rob), 64'd36);
        tick;
        tick;

        // Flush a full station while inserts and forwards are offered.
        flush = 1'b1;
        tick;
        flush = 1'b0;
        check("t5_clr", 64'(in_ready), 64'd1);
        for (int g = 0; g < 4; g++) begin
            for (int c = 0; c < 4; c++)
                put(c, 4, 16 + g * 4 + c, 40 + g * 4 + c, 0, 0, 0, 0, 1);
            tick;
        end
        idle;
        check("t5_full", 64'(in_ready), 64'd0);
        flush = 1'b1;
        for (int c = 0; c < 4; c++) begin
            put(c, 2, 60 + c, 0, 0, 1, 1, 1, 1);
            bus(c, 40 + c, 16'h0700 + c);
        end
        tick;
        flush = 1'b0;
        idle;
        check("t5_ov", 64'(out_valid), 64'd0);
        check("t5_rdy", 64'(in_ready), 64'd1);
        for (int k = 0; k < 4; k++)
            bus(k, 40 + k, 16'h0800 + k);
        tick;
        idle;
        for (int i = 0; i < 4; i++) begin
            tick;
            check("t5_quiet", 64'(out_valid), 64'd0);
        end

        // Reset with a pending output and queued entries.
        out_ready = 1'b0;
        for (int c = 0; c < 4; c++)
            put(c, 5, 50 + c, 0, 0, 3, 3, 1, 1);
        tick;
        idle;
        tick;
        check("t6_pend", 64'(out_valid), 64'd1);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("t6_ov", 64'(out_valid), 64'd0);
        check("t6_rob", 64'(out_rob), 64'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            check("t6_quiet", 64'(out_valid), 64'd0);
        end

`ifdef ALU_RS_FWD_BYPASS_EN
        put(0, 6, 12, 0, 7, 1, 0, 1, 0);
        bus(0, 7, 16'hBEEF);
        sb.push_back(pack(6, 12, 1, 16'hBEEF));
        tick;
        idle;
        tick;
        check("t7_v", 64'(out_valid), 64'd1);
        check("t7_b", 64'(out_b), 64'hBEEF);
        tick;
`endif

        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
